// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the call-stack controller and its storage.
// Optional trap behaviour is selected with the CALL_STACK_TRAP_EN macro.
package cpu_pkg;

  // Width of a program-counter / return address.
  localparam int ADDR_W = 10;

  // Default number of return-address entries in the call stack.
  localparam int CS_DEPTH_DEFAULT = 8;

  // Call-stack controller state.
  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } cs_state_e;

  // Reported stack error.
  typedef enum logic [1:0] {
    FC_NONE = 2'b00,
    FC_OVF  = 2'b01,
    FC_UNF  = 2'b10
  } cs_fault_e;

  // Index width for a stack of the given depth (at least one bit).
  function automatic int cs_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/call_stack_mem.sv
// Return-address storage: one synchronous write port, one combinational read port.
// Contents are never reset; the controller's depth decides which entries are live.
module call_stack_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH  = CS_DEPTH_DEFAULT,
  parameter int DATA_W = ADDR_W,
  parameter int IDX_W  = cs_idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write the addressed entry on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Asynchronous read so the top of stack is visible in the same cycle.
  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/call_stack_ctrl.sv
// Hardware return-address stack for the PC unit.
// Calls push npc, returns pop; the top entry is presented on rl with zero latency.
// Define CALL_STACK_TRAP_EN to trap on overflow/underflow into a sticky FAULT state;
// otherwise overflow overwrites the top entry and underflow is ignored.
module call_stack_ctrl
  import cpu_pkg::*;
#(
  parameter int DEPTH = CS_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     start,
  input  logic                     branch,
  input  logic                     jump2sub,
  input  logic                     retFsub,
  input  logic [ADDR_W-1:0]        npc,
  output logic [ADDR_W-1:0]        rl,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     empty,
  output logic                     full,
  output logic                     fault,
  output logic [1:0]               fault_code
);

  localparam int DW = $clog2(DEPTH) + 1;
  localparam int AW = cs_idx_w(DEPTH);

  // Control state
  cs_state_e         state_q, state_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              fault_q, fault_d;
  cs_fault_e         code_q, code_d;

  // Storage port signals
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [AW-1:0]     mem_raddr;
  logic [ADDR_W-1:0] mem_rdata;

  // Requests after the PC's priority: branch beats call beats return.
  logic push_req;
  logic pop_req;
  logic at_full;
  logic at_empty;

  // Decode prioritised requests and current occupancy.
  always_comb begin
    push_req = jump2sub & ~branch;
    pop_req  = retFsub & ~branch & ~jump2sub;
    at_full  = (depth_q == DW'(DEPTH));
    at_empty = (depth_q == '0);
  end

  // Next-state, depth and write-port computation.
  always_comb begin
    state_d   = state_q;
    depth_d   = depth_q;
    fault_d   = fault_q;
    code_d    = code_q;
    mem_we    = 1'b0;
    mem_waddr = depth_q[AW-1:0];

    if (state_q == RUN) begin
      if (push_req) begin
        if (!at_full) begin
          mem_we  = 1'b1;
          depth_d = depth_q + DW'(1);
        end else begin
`ifdef CALL_STACK_TRAP_EN
          state_d = FAULT;
          fault_d = 1'b1;
          code_d  = FC_OVF;
`else
          // Keep the newest return address by replacing the top entry.
          mem_we    = 1'b1;
          mem_waddr = AW'(DEPTH - 1);
`endif
        end
      end else if (pop_req) begin
        if (!at_empty) begin
          depth_d = depth_q - DW'(1);
        end else begin
`ifdef CALL_STACK_TRAP_EN
          state_d = FAULT;
          fault_d = 1'b1;
          code_d  = FC_UNF;
`endif
        end
      end
    end

    // A request that coincides with reset must not touch storage.
    if (start) begin
      mem_we = 1'b0;
    end

    empty_d = (depth_d == '0);
    full_d  = (depth_d == DW'(DEPTH));
  end

  // FSM and registered status; reset returns to an empty, fault-free RUN.
  always_ff @(posedge clk) begin
    if (start) begin
      state_q <= RUN;
      depth_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  // Top of stack lives at depth-1; the address wraps harmlessly when empty.
  always_comb begin
    mem_raddr = AW'(depth_q - DW'(1));
  end

  call_stack_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (ADDR_W),
    .IDX_W  (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (npc),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // Output drive: rl is combinational for zero-latency returns, status is registered.
  always_comb begin
    rl         = (depth_q == '0) ? '0 : mem_rdata;
    depth      = depth_q;
    empty      = empty_q;
    full       = full_q;
`ifdef CALL_STACK_TRAP_EN
    fault      = fault_q;
    fault_code = code_q;
`else
    fault      = 1'b0;
    fault_code = 2'b00;
`endif
  end

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Directed bench for call_stack_ctrl (DEPTH=8); follows CALL_STACK_TRAP_EN if defined.
module tb_call_stack_ctrl;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       start = 1'b0;
  logic       branch = 1'b0;
  logic       jump2sub = 1'b0;
  logic       retFsub = 1'b0;
  logic [9:0] npc = '0;
  logic [9:0] rl;
  logic [3:0] depth;
  logic       empty;
  logic       full;
  logic       fault;
  logic [1:0] fault_code;

  int total = 0;
  int bad = 0;

  call_stack_ctrl #(.DEPTH(8)) dut (
    .clk        (clk),
    .start      (start),
    .branch     (branch),
    .jump2sub   (jump2sub),
    .retFsub    (retFsub),
    .npc        (npc),
    .rl         (rl),
    .depth      (depth),
    .empty      (empty),
    .full       (full),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    start = 1'b0; branch = 1'b0; jump2sub = 1'b0; retFsub = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic push(input logic [9:0] a);
    idle();
    jump2sub = 1'b1; npc = a;
    step();
    idle();
  endtask

  task automatic pop();
    idle();
    retFsub = 1'b1;
    step();
    idle();
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_depth", 16'(depth), 16'h0);
    chk("rst_empty", 16'(empty), 16'h1);
    chk("rst_full", 16'(full), 16'h0);
    chk("rst_rl", 16'(rl), 16'h000);
    chk("rst_fault", 16'(fault), 16'h0);
    chk("rst_code", 16'(fault_code), 16'h0);

    // Two pushes, then a pop with zero-latency rl
    push(10'h105);
    chk("p1_depth", 16'(depth), 16'h1);
    chk("p1_rl", 16'(rl), 16'h105);
    push(10'h2A0);
    chk("p2_depth", 16'(depth), 16'h2);
    chk("p2_rl", 16'(rl), 16'h2A0);
    chk("p2_empty", 16'(empty), 16'h0);
    retFsub = 1'b1;
    #1;
    chk("pop_rl_during", 16'(rl), 16'h2A0);
    step();
    idle();
    chk("pop_rl_after", 16'(rl), 16'h105);
    chk("pop_depth", 16'(depth), 16'h1);

    // Priority resolution at depth 3
    push(10'h111);
    push(10'h122);
    chk("d3_depth", 16'(depth), 16'h3);
    branch = 1'b1; jump2sub = 1'b1; retFsub = 1'b1; npc = 10'h3FF;
    step();
    idle();
    chk("br_depth", 16'(depth), 16'h3);
    chk("br_rl", 16'(rl), 16'h122);
    jump2sub = 1'b1; retFsub = 1'b1; npc = 10'h133;
    step();
    idle();
    chk("jr_depth", 16'(depth), 16'h4);
    chk("jr_rl", 16'(rl), 16'h133);

    // Unwind to confirm stored entries were untouched
    pop();
    chk("uw1_rl", 16'(rl), 16'h122);
    pop();
    chk("uw2_rl", 16'(rl), 16'h111);
    pop();
    chk("uw3_rl", 16'(rl), 16'h105);
    pop();
    chk("uw4_depth", 16'(depth), 16'h0);
    chk("uw4_empty", 16'(empty), 16'h1);
    chk("uw4_rl", 16'(rl), 16'h000);

    // Underflow
    pop();
`ifdef CALL_STACK_TRAP_EN
    chk("unf_fault", 16'(fault), 16'h1);
    chk("unf_code", 16'(fault_code), 16'h2);
    push(10'h055);
    chk("unf_push_ignored", 16'(depth), 16'h0);
    chk("unf_fault_hold", 16'(fault), 16'h1);
`else
    chk("unf_depth", 16'(depth), 16'h0);
    chk("unf_rl", 16'(rl), 16'h000);
    chk("unf_fault", 16'(fault), 16'h0);
    chk("unf_empty", 16'(empty), 16'h1);
`endif

    // Overflow: nine pushes 0x010..0x018
    do_reset();
    chk("ovr_rst_code", 16'(fault_code), 16'h0);
    for (int i = 0; i < 8; i++) push(10'(16 + i));
    chk("full_depth", 16'(depth), 16'h8);
    chk("full_flag", 16'(full), 16'h1);
    chk("full_rl", 16'(rl), 16'h017);
    push(10'h018);
`ifdef CALL_STACK_TRAP_EN
    chk("ovf_fault", 16'(fault), 16'h1);
    chk("ovf_code", 16'(fault_code), 16'h1);
    chk("ovf_depth", 16'(depth), 16'h8);
    chk("ovf_rl", 16'(rl), 16'h017);
    pop();
    chk("ovf_pop_ignored", 16'(depth), 16'h8);
`else
    chk("ovf_depth", 16'(depth), 16'h8);
    chk("ovf_rl", 16'(rl), 16'h018);
    chk("ovf_fault", 16'(fault), 16'h0);
    chk("ovf_full", 16'(full), 16'h1);
    pop();
    chk("ovf_pop_depth", 16'(depth), 16'h7);
    chk("ovf_pop_rl", 16'(rl), 16'h016);
`endif

    // Reset mid-sequence at depth 5 with a coincident call
    do_reset();
    for (int i = 0; i < 5; i++) push(10'(10'h040 + i));
    chk("mid_depth5", 16'(depth), 16'h5);
    start = 1'b1; jump2sub = 1'b1; npc = 10'h1AB;
    step();
    idle();
    chk("mid_depth", 16'(depth), 16'h0);
    chk("mid_empty", 16'(empty), 16'h1);
    chk("mid_full", 16'(full), 16'h0);
    chk("mid_rl", 16'(rl), 16'h000);
    chk("mid_fault", 16'(fault), 16'h0);
    chk("mid_code", 16'(fault_code), 16'h0);
    push(10'h2C3);
    chk("mid_run_depth", 16'(depth), 16'h1);
    chk("mid_run_rl", 16'(rl), 16'h2C3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
